tdp_bytewise_pipelined_ram: RTL and testbench

//  Single-clock true dual-port RAM, two independent request/response ports (A, B).

---
 rtl/tdp_ram_pkg.sv | 16 +
 rtl/tdp_ram_out_pipe.sv | 37 +++
 rtl/tdp_bytewise_pipelined_ram.sv | 115 +++++++++++
 tb/tb_tdp_bytewise_pipelined_ram.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tdp_ram_pkg.sv
// tdp_ram_pkg: write-mode enum, parameter-string decoding and a width-generic byte-lane merge
package tdp_ram_pkg;
  localparam int MAX_W = 1024;
  localparam int MAX_LG = 10;
  typedef enum logic [1:0] {WM_READ_FIRST, WM_WRITE_FIRST, WM_NO_CHANGE} write_mode_e;
  function automatic write_mode_e str2mode(input string s);
    return s == "WRITE_FIRST" ? WM_WRITE_FIRST : s == "NO_CHANGE" ? WM_NO_CHANGE : WM_READ_FIRST;
  endfunction
  // Callers zero-extend into MAX_W and truncate the result back to their own width
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_W-1:0] be, input int byte_w);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) r[i] = be[MAX_LG'(i / byte_w)] ? new_w[i] : old_w[i];
    return r;
  endfunction
endpackage

// File: rtl/tdp_ram_out_pipe.sv
// tdp_ram_out_pipe: N-deep valid/data output register chain; a stage's data only moves with its valid bit
module tdp_ram_out_pipe #(
  parameter int W = 32,
  parameter int N = 1
) (
  input  logic         clka,
  input  logic         rstb,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  if (N == 0) begin : g_pass
    assign out_valid = in_valid;
    assign out_data = in_data;
  end else begin : g_pipe
    logic [N-1:0] v_d, v_q;
    logic [N-1:0][W-1:0] d_d, d_q, d_sh;
    always_comb begin
      v_d = (v_q << 1) | N'(in_valid);
      d_sh = d_q << W;
      d_sh[0] = in_data;
      for (int i = 0; i < N; i++) d_d[i] = v_d[i] ? d_sh[i] : d_q[i];
    end
    always_ff @(posedge clka) begin
      if (rstb) begin
        v_q <= '0;
        d_q <= '0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end
    assign out_valid = v_q[N-1];
    assign out_data = d_q[N-1];
  end
endmodule

// File: rtl/tdp_bytewise_pipelined_ram.sv
// tdp_bytewise_pipelined_ram: single-clock true dual-port RAM with byte enables and pipelined responses.
// Define TDP_RAM_COLLISION_FLAG_EN to add the coll_pulse / coll_cnt same-address collision outputs.
module tdp_bytewise_pipelined_ram
  import tdp_ram_pkg::*;
#(
  parameter int    DATA_W     = 32,
  parameter int    BYTE_W     = 8,
  parameter int    DEPTH      = 1024,
  parameter string WRITE_MODE = "READ_FIRST",
  parameter int    OUT_STAGES = 1,
  parameter string INIT_FILE  = "",
  localparam int   NB         = DATA_W / BYTE_W,
  localparam int   AW         = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clka,
  input  logic              rstb,
  input  logic              a_req_valid,
  input  logic              a_req_we,
  input  logic [NB-1:0]     a_req_be,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req_valid,
  input  logic              b_req_we,
  input  logic [NB-1:0]     b_req_be,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rdata
`ifdef TDP_RAM_COLLISION_FLAG_EN
  ,
  output logic              coll_pulse,
  output logic [15:0]       coll_cnt
`endif
);
  localparam write_mode_e WM = str2mode(WRITE_MODE);
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] n,
                                              input logic [NB-1:0] be);
    return DATA_W'(byte_merge(MAX_W'(o), MAX_W'(n), MAX_W'(be), BYTE_W));
  endfunction
  logic [DATA_W-1:0] mem [DEPTH];
  logic a_acc, b_acc, a_in, b_in, a_wr, b_wr, same;
  logic [NB-1:0] a_be_w, b_be_w;
  logic [DATA_W-1:0] a_old, b_old, a_new, b_new;
  logic a_v_d, a_v_q, b_v_d, b_v_q;
  logic [DATA_W-1:0] a_d_d, a_d_q, b_d_d, b_d_q;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end
  // On a shared address port A owns every lane it enables; B keeps only its remaining lanes
  always_comb begin
    a_acc = a_req_valid & ~rstb;
    b_acc = b_req_valid & ~rstb;
    a_in = {1'b0, a_addr} < (AW+1)'(DEPTH);
    b_in = {1'b0, b_addr} < (AW+1)'(DEPTH);
    a_old = a_in ? mem[a_addr] : '0;
    b_old = b_in ? mem[b_addr] : '0;
    a_wr = a_acc & a_req_we & a_in;
    b_wr = b_acc & b_req_we & b_in;
    same = a_addr == b_addr;
    a_be_w = a_wr ? a_req_be : '0;
    b_be_w = b_wr ? b_req_be & ~(same ? a_be_w : '0) : '0;
    a_new = merge(merge(a_old, b_wdata, same ? b_be_w : '0), a_wdata, a_be_w);
    b_new = merge(merge(b_old, b_wdata, b_be_w), a_wdata, same ? a_be_w : '0);
    a_v_d = a_acc & ~(WM == WM_NO_CHANGE & a_req_we);
    b_v_d = b_acc & ~(WM == WM_NO_CHANGE & b_req_we);
    a_d_d = a_v_d ? (WM == WM_WRITE_FIRST ? a_new : a_old) : a_d_q;
    b_d_d = b_v_d ? (WM == WM_WRITE_FIRST ? b_new : b_old) : b_d_q;
  end
  always_ff @(posedge clka) begin
    for (int i = 0; i < NB; i++) begin
      if (a_be_w[i]) mem[a_addr][i*BYTE_W +: BYTE_W] <= a_wdata[i*BYTE_W +: BYTE_W];
      if (b_be_w[i]) mem[b_addr][i*BYTE_W +: BYTE_W] <= b_wdata[i*BYTE_W +: BYTE_W];
    end
  end
  always_ff @(posedge clka) begin
    if (rstb) begin
      a_v_q <= 1'b0;
      b_v_q <= 1'b0;
      a_d_q <= '0;
      b_d_q <= '0;
    end else begin
      a_v_q <= a_v_d;
      b_v_q <= b_v_d;
      a_d_q <= a_d_d;
      b_d_q <= b_d_d;
    end
  end
  tdp_ram_out_pipe #(.W(DATA_W), .N(OUT_STAGES)) u_a_pipe (
    .clka(clka), .rstb(rstb), .in_valid(a_v_q), .in_data(a_d_q), .out_valid(a_rsp_valid), .out_data(a_rdata)
  );
  tdp_ram_out_pipe #(.W(DATA_W), .N(OUT_STAGES)) u_b_pipe (
    .clka(clka), .rstb(rstb), .in_valid(b_v_q), .in_data(b_d_q), .out_valid(b_rsp_valid), .out_data(b_rdata)
  );
`ifdef TDP_RAM_COLLISION_FLAG_EN
  logic coll_pulse_d, coll_pulse_q;
  logic [15:0] coll_cnt_d, coll_cnt_q;
  always_comb begin
    coll_pulse_d = a_acc & b_acc & same & (a_req_we | b_req_we);
    coll_cnt_d = coll_cnt_q + 16'(coll_pulse_d & ~&coll_cnt_q);
  end
  always_ff @(posedge clka) begin
    if (rstb) begin
      coll_pulse_q <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_pulse_q <= coll_pulse_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end
  assign coll_pulse = coll_pulse_q;
  assign coll_cnt = coll_cnt_q;
`endif
endmodule

// File: tb/tb_tdp_bytewise_pipelined_ram.sv
// tb_tdp_bytewise_pipelined_ram: scoreboard bench driving READ_FIRST/1, WRITE_FIRST/3 and NO_CHANGE/0 builds
module tb_tdp_bytewise_pipelined_ram;
  typedef struct { int k; int p; int cyc; logic [31:0] d; } exp_t;
  logic clka = 1'b0, rstb = 1'b1;
  logic a_req_valid = 1'b0, a_req_we = 1'b0, b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [3:0] a_req_be = '0, b_req_be = '0;
  logic [9:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic a_rsp_valid [3], b_rsp_valid [3];
  logic [31:0] a_rdata [3], b_rdata [3];
`ifdef TDP_RAM_COLLISION_FLAG_EN
  logic coll_pulse [3];
  logic [15:0] coll_cnt [3];
  bit coll_at [int];
  int coll_total = 0;
`endif
  exp_t sb[$];
  logic [31:0] mm [1000];
  int cyc = 0, n_chk = 0, n_pass = 0;
  bit mon_en = 1'b0;

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tdp_bytewise_pipelined_ram #(
      .DEPTH(1000),
      .WRITE_MODE(g == 0 ? "READ_FIRST" : g == 1 ? "WRITE_FIRST" : "NO_CHANGE"),
      .OUT_STAGES(g == 0 ? 1 : g == 1 ? 3 : 0)
    ) dut (
      .clka(clka), .rstb(rstb),
      .a_req_valid(a_req_valid), .a_req_we(a_req_we), .a_req_be(a_req_be), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid[g]), .a_rdata(a_rdata[g]),
      .b_req_valid(b_req_valid), .b_req_we(b_req_we), .b_req_be(b_req_be), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid[g]), .b_rdata(b_rdata[g])
`ifdef TDP_RAM_COLLISION_FLAG_EN
      , .coll_pulse(coll_pulse[g]), .coll_cnt(coll_cnt[g])
`endif
    );
  end

  function automatic int os_of(input int k);
    return k == 0 ? 1 : k == 1 ? 3 : 0;
  endfunction
  function automatic logic [31:0] bm(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction
  function automatic logic [31:0] rd(input logic [9:0] x);
    return x < 10'd1000 ? mm[x] : 32'h0;
  endfunction
  // Word that address x holds after this cycle's writes: B's lanes first, A's lanes on top
  function automatic logic [31:0] nw(input logic [9:0] x, input logic wa, input logic [9:0] aad,
                                     input logic [3:0] abe, input logic [31:0] awd, input logic wb,
                                     input logic [9:0] bad, input logic [3:0] bbe, input logic [31:0] bwd);
    logic [31:0] w;
    w = rd(x);
    if (wb && bad == x && x < 10'd1000) w = bm(w, bwd, bbe);
    if (wa && aad == x && x < 10'd1000) w = bm(w, awd, abe);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clka) if (mon_en) begin
`ifdef TDP_RAM_COLLISION_FLAG_EN
    bit ce;
    ce = coll_at.exists(cyc);
    if (ce) coll_total++;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("coll_pulse k%0d cyc%0d", k, cyc), 32'(coll_pulse[k]), 32'(ce));
      chk($sformatf("coll_cnt k%0d cyc%0d", k, cyc), 32'(coll_cnt[k]), 32'(coll_total));
    end
`endif
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        int idx;
        idx = -1;
        foreach (sb[i]) if (sb[i].k == k && sb[i].p == p && sb[i].cyc == cyc) idx = i;
        chk($sformatf("rsp_valid k%0d p%0d cyc%0d", k, p, cyc),
            32'(p == 1 ? b_rsp_valid[k] : a_rsp_valid[k]), 32'(idx >= 0));
        if (idx >= 0) begin
          chk($sformatf("rdata k%0d p%0d cyc%0d", k, p, cyc), p == 1 ? b_rdata[k] : a_rdata[k], sb[idx].d);
          sb.delete(idx);
        end
      end
    end
  end

  task automatic step(input logic av, input logic aw, input logic [3:0] abe, input logic [9:0] aad,
                      input logic [31:0] awd, input logic bv, input logic bw, input logic [3:0] bbe,
                      input logic [9:0] bad, input logic [31:0] bwd);
    logic [31:0] ao, bo, an, bn;
    @(negedge clka);
    a_req_valid = av; a_req_we = aw; a_req_be = abe; a_addr = aad; a_wdata = awd;
    b_req_valid = bv; b_req_we = bw; b_req_be = bbe; b_addr = bad; b_wdata = bwd;
    ao = rd(aad);
    bo = rd(bad);
    an = nw(aad, av && aw, aad, abe, awd, bv && bw, bad, bbe, bwd);
    bn = nw(bad, av && aw, aad, abe, awd, bv && bw, bad, bbe, bwd);
    for (int k = 0; k < 3; k++) begin
      if (av && !(k == 2 && aw)) sb.push_back('{k, 0, cyc + 1 + os_of(k), k == 1 ? an : ao});
      if (bv && !(k == 2 && bw)) sb.push_back('{k, 1, cyc + 1 + os_of(k), k == 1 ? bn : bo});
    end
    if (bv && bw && bad < 10'd1000) mm[bad] = bm(mm[bad], bwd, bbe);
    if (av && aw && aad < 10'd1000) mm[aad] = bm(mm[aad], awd, abe);
`ifdef TDP_RAM_COLLISION_FLAG_EN
    if (av && bv && aad == bad && (aw || bw)) coll_at[cyc + 1] = 1'b1;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 4'h0, 10'd0, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
  endtask

  // Colliding writes are driven during reset; they must leave memory and the counter untouched
  task automatic do_reset();
    @(negedge clka);
    mon_en = 1'b0;
    rstb = 1'b1;
    a_req_valid = 1; a_req_we = 1; a_req_be = 4'hF; a_addr = 10'd3; a_wdata = 32'hDEADBEEF;
    b_req_valid = 1; b_req_we = 1; b_req_be = 4'hF; b_addr = 10'd3; b_wdata = 32'h0BADF00D;
    repeat (2) @(negedge clka);
    rstb = 1'b0;
    a_req_valid = 0;
    b_req_valid = 0;
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset a_rsp_valid k%0d", k), 32'(a_rsp_valid[k]), 32'h0);
      chk($sformatf("reset b_rsp_valid k%0d", k), 32'(b_rsp_valid[k]), 32'h0);
      chk($sformatf("reset a_rdata k%0d", k), a_rdata[k], 32'h0);
      chk($sformatf("reset b_rdata k%0d", k), b_rdata[k], 32'h0);
    end
`ifdef TDP_RAM_COLLISION_FLAG_EN
    coll_at.delete();
    coll_total = 0;
    for (int k = 0; k < 3; k++) chk($sformatf("reset coll_cnt k%0d", k), 32'(coll_cnt[k]), 32'h0);
`endif
    mon_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1000; i++) mm[i] = 32'h0;
    do_reset();
    step(1, 0, 4'h0, 10'd5, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
    step(1, 1, 4'hF, 10'd3, 32'h11223344, 0, 0, 4'h0, 10'd0, 32'h0);
    step(1, 1, 4'b0101, 10'd3, 32'hAABBCCDD, 0, 0, 4'h0, 10'd0, 32'h0);
    step(1, 0, 4'h0, 10'd3, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
    step(1, 1, 4'b0001, 10'd7, 32'h000000FF, 1, 1, 4'b1101, 10'd7, 32'hFFFF0000);
    step(0, 0, 4'h0, 10'd0, 32'h0, 1, 0, 4'h0, 10'd7, 32'h0);
    step(1, 1, 4'hF, 10'd9, 32'hCAFEF00D, 1, 0, 4'h0, 10'd9, 32'h0);
    step(1, 1, 4'h0, 10'd9, 32'h12345678, 1, 1, 4'hF, 10'd999, 32'h55555555);
    step(1, 0, 4'h0, 10'd1000, 32'h0, 1, 1, 4'hF, 10'd1010, 32'h00000001);
    step(1, 0, 4'h0, 10'd999, 32'h0, 1, 0, 4'h0, 10'd9, 32'h0);
    idle(5);
    for (int i = 0; i < 16; i++) step(1, 0, 4'h0, 10'(i), 32'h0, 1, 1, 4'(i), 10'(i), $urandom());
    idle(5);
    repeat (80) begin
      logic [9:0] aa, ba;
      aa = $urandom_range(0, 3) == 0 ? 10'(998 + $urandom_range(0, 3)) : 10'($urandom_range(0, 7));
      ba = $urandom_range(0, 3) == 0 ? 10'(998 + $urandom_range(0, 3)) : 10'($urandom_range(0, 7));
      step(1'($urandom), 1'($urandom), 4'($urandom), aa, $urandom(),
           1'($urandom), 1'($urandom), 4'($urandom), ba, $urandom());
    end
    idle(5);
    step(1, 0, 4'h0, 10'd3, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
    step(1, 0, 4'h0, 10'd7, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
    do_reset();
    step(1, 0, 4'h0, 10'd3, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
    step(0, 0, 4'h0, 10'd0, 32'h0, 1, 0, 4'h0, 10'd7, 32'h0);
    idle(6);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
